multicycle_sequencer: RTL and testbench

- Moore/Mealy FSM that steps the KGP-RISC datapath through FETCH, DECODE, EXEC, MEM and WB phases.
- Gates the enables produced by the instruction decoder: IR load, register file write, flag write, data memory request and PC update.
- Handles variable-latency instruction/data memory and the multi-cycle multiplier through ready/done handshakes, with a watchdog on every wait.
- Sits between the top-level core and the decoder/datapath. It owns "when"; the decoder owns "what".

---
 rtl/multicycle_sequencer.sv | 164 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Phase sequencer for the KGP-RISC datapath: FETCH/DECODE/EXEC/MEM/WB with watchdog-guarded handshakes.
// Optional retired-instruction counter enabled by defining SEQ_INSTR_COUNT_EN.
module multicycle_sequencer #(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter logic [5:0]  HALT_OP    = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        alu_done,
  output logic        imem_req,
  output logic        ir_wren,
  output logic        alu_start,
  output logic        flags_wren,
  output logic        dmem_req,
  output logic        rf_wren_gate,
  output logic        pc_wren,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic is_mul, is_branch, is_sw, is_mem;
  logic waiting, satisfied, timeout;

  always_comb begin
    is_mul    = (opcode == 6'b000000) && ((funct == 6'b011000) || (funct == 6'b011001));
    is_branch = opcode[4] || ((opcode == 6'b000000) && (funct == 6'b001000));
    is_sw     = (opcode == 6'b101011);
    is_mem    = (opcode == 6'b100011) || is_sw;
  end

  // A wait that hits the limit without its handshake diverts to ERROR; a
  // handshake in that same cycle still wins.
  always_comb begin
    waiting   = 1'b0;
    satisfied = 1'b0;
    case (state_q)
      S_FETCH: begin waiting = 1'b1;   satisfied = imem_ready; end
      S_MEM:   begin waiting = 1'b1;   satisfied = dmem_ready; end
      S_EXEC:  begin waiting = is_mul; satisfied = alu_done;   end
      default: ;
    endcase
    timeout = waiting && !satisfied && (wait_q == 8'(WAIT_LIMIT - 1));
  end

  always_comb begin
    state_d      = state_q;
    imem_req     = 1'b0;
    ir_wren      = 1'b0;
    alu_start    = 1'b0;
    flags_wren   = 1'b0;
    dmem_req     = 1'b0;
    rf_wren_gate = 1'b0;
    pc_wren      = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_wren = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        if (opcode == HALT_OP) begin
          state_d = S_HALTED;
        end else begin
          alu_start = is_mul;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mul && !alu_done) begin
          if (timeout) state_d = S_ERROR;
        end else if (is_branch) begin
          pc_wren = 1'b1;
          state_d = S_FETCH;
        end else if (is_mem) begin
          state_d = S_MEM;
        end else begin
          flags_wren = 1'b1;
          state_d    = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          if (is_sw) begin
            pc_wren = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        rf_wren_gate = 1'b1;
        pc_wren      = 1'b1;
        state_d      = S_FETCH;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (state_d != state_q)        wait_d = 8'd0;
    else if (waiting && !satisfied) wait_d = wait_q + 8'd1;
    else                            wait_d = wait_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign busy   = !((state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_ERROR));
  assign halted = (state_q == S_HALTED);
  assign err    = (state_q == S_ERROR);
  assign state  = state_q;

`ifdef SEQ_INSTR_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          count_q <= 32'd0;
    else if (pc_wren) count_q <= count_q + 32'd1;
  end

  assign instr_count = count_q;
`else
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: each instruction is expanded into its expected
// per-cycle phase trace from class and handshake delays, then replayed against the DUT.
module tb_multicycle_sequencer;

  localparam int LIM = 4;
  localparam logic [5:0] HALT = 6'b111111;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3,
                         ST_M = 3'd4, ST_WB = 3'd5, ST_H = 3'd6, ST_ERR = 3'd7;

  // strobe vector order: imem_req ir_wren alu_start flags_wren dmem_req rf_wren_gate pc_wren
  localparam logic [6:0] IMQ = 7'b1000000, IRW = 7'b0100000, AST = 7'b0010000,
                         FLW = 7'b0001000, DMQ = 7'b0000100, RFW = 7'b0000010,
                         PCW = 7'b0000001;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0, alu_done = 1'b0;
  logic imem_req, ir_wren, alu_start, flags_wren, dmem_req, rf_wren_gate, pc_wren;
  logic busy, halted, err;
  logic [2:0] state;
  logic [31:0] instr_count;

  multicycle_sequencer #(.WAIT_LIMIT(LIM), .HALT_OP(HALT)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct(funct),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .alu_done(alu_done),
    .imem_req(imem_req), .ir_wren(ir_wren), .alu_start(alu_start),
    .flags_wren(flags_wren), .dmem_req(dmem_req), .rf_wren_gate(rf_wren_gate),
    .pc_wren(pc_wren), .busy(busy), .halted(halted), .err(err),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [6:0] strb;
    logic [2:0] fl;      // busy halted err
    logic [1:0] which;   // 0 none, 1 imem_ready, 2 dmem_ready, 3 alu_done
    logic       rdy;
    logic       retire;
  } step_t;

  step_t plan[$];
  int n_cmp = 0, n_bad = 0;
  int exp_cnt = 0;
  bit term;
  logic [5:0] cur_op, cur_fn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_icount();
`ifdef SEQ_INSTR_COUNT_EN
    return 32'(exp_cnt);
`else
    return 32'd0;
`endif
  endfunction

  function automatic void push(logic [2:0] st, logic [6:0] strb, logic [1:0] which,
                               logic rdy, logic retire);
    step_t s;
    s.st     = st;
    s.strb   = strb;
    s.fl     = {(st >= ST_F && st <= ST_WB), st == ST_H, st == ST_ERR};
    s.which  = which;
    s.rdy    = rdy;
    s.retire = retire;
    plan.push_back(s);
  endfunction

  function automatic void push_end(logic [2:0] st);
    for (int i = 0; i < 3; i++) push(st, 7'b0, 2'd0, 1'b0, 1'b0);
    term = 1'b1;
  endfunction

  // A handshake wait of delay d: success on cycle d if that falls within LIM cycles.
  function automatic bit wait_phase(logic [2:0] st, logic [6:0] base, logic [6:0] done,
                                    logic [1:0] which, int d, logic ret);
    for (int i = 0; i < LIM; i++) begin
      if (i == d) begin
        push(st, base | done, which, 1'b1, ret);
        return 1'b1;
      end
      push(st, base, which, 1'b0, 1'b0);
    end
    return 1'b0;
  endfunction

  function automatic void build_plan(logic [5:0] op, logic [5:0] fn, int di, int da, int dm);
    bit mul, br, lw, sw;
    mul = (op == 6'd0) && (fn == 6'b011000 || fn == 6'b011001);
    br  = op[4] || (op == 6'd0 && fn == 6'b001000);
    lw  = (op == 6'b100011);
    sw  = (op == 6'b101011);
    plan.delete();
    term = 1'b0;
    if (!wait_phase(ST_F, IMQ, IRW, 2'd1, di, 1'b0)) begin push_end(ST_ERR); return; end
    if (op == HALT) begin
      push(ST_D, 7'b0, 2'd0, 1'b0, 1'b0);
      push_end(ST_H);
      return;
    end
    push(ST_D, mul ? AST : 7'b0, 2'd0, 1'b0, 1'b0);
    if (mul) begin
      if (!wait_phase(ST_E, 7'b0, FLW, 2'd3, da, 1'b0)) begin push_end(ST_ERR); return; end
      push(ST_WB, RFW | PCW, 2'd0, 1'b0, 1'b1);
    end else if (br) begin
      push(ST_E, PCW, 2'd0, 1'b0, 1'b1);
    end else if (lw || sw) begin
      push(ST_E, 7'b0, 2'd0, 1'b0, 1'b0);
      if (!wait_phase(ST_M, DMQ, sw ? PCW : 7'b0, 2'd2, dm, sw)) begin
        push_end(ST_ERR);
        return;
      end
      if (lw) push(ST_WB, RFW | PCW, 2'd0, 1'b0, 1'b1);
    end else begin
      push(ST_E, FLW, 2'd0, 1'b0, 1'b0);
      push(ST_WB, RFW | PCW, 2'd0, 1'b0, 1'b1);
    end
  endfunction

  function automatic logic [6:0] strobes();
    return {imem_req, ir_wren, alu_start, flags_wren, dmem_req, rf_wren_gate, pc_wren};
  endfunction

  task automatic do_step(input step_t s);
    @(negedge clk);
    opcode     = cur_op;
    funct      = cur_fn;
    start      = 1'($urandom_range(0, 1));
    imem_ready = (s.which == 2'd1) ? s.rdy : 1'($urandom_range(0, 1));
    dmem_ready = (s.which == 2'd2) ? s.rdy : 1'($urandom_range(0, 1));
    alu_done   = (s.which == 2'd3) ? s.rdy : 1'($urandom_range(0, 1));
    #1;
    check("state", 32'(state), 32'(s.st));
    check("strobes", 32'(strobes()), 32'(s.strb));
    check("busy_halt_err", 32'({busy, halted, err}), 32'(s.fl));
    check("instr_count", instr_count, exp_icount());
    if (s.retire) exp_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    imem_ready = 1'b1; dmem_ready = 1'b1; alu_done = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_outputs", 32'({strobes(), busy, halted, err}), 32'd0);
    check("rst_count", instr_count, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b0;
    #1;
    check("idle_hold", 32'({state, strobes(), busy, halted, err}), 32'd0);
    @(negedge clk);
    start = 1'b1;
    #1;
    check("idle_start", 32'({state, strobes(), busy, halted, err}), 32'd0);
  endtask

  // abort_idx >= 0 asserts rst asynchronously inside that step.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int di,
                     input int da, input int dm, input int abort_idx);
    cur_op = op;
    cur_fn = fn;
    build_plan(op, fn, di, da, dm);
    for (int i = 0; i < plan.size(); i++) begin
      do_step(plan[i]);
      if (i == abort_idx) begin
        rst = 1'b1;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_dmem_req", 32'(dmem_req), 32'd0);
        term = 1'b1;
        break;
      end
    end
    if (term) begin
      do_reset();
      start_pulse();
    end
  endtask

  function automatic int rnd_delay();
    return ($urandom_range(0, 19) == 0) ? 9 : int'($urandom_range(0, LIM - 1));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    cur_op = '0;
    cur_fn = '0;
    do_reset();
    start_pulse();
    run(6'b000000, 6'b100000, 0, 0, 0, -1);     // ADD
    run(6'b100011, 6'b000000, 0, 0, 3, -1);     // LW, dmem_ready on the limit cycle
    run(6'b000000, 6'b011000, 0, 2, 0, -1);     // MULT, alu_done on 3rd EXEC cycle
    run(6'b010000, 6'b000000, 0, 0, 0, -1);     // branch
    run(6'b101011, 6'b000000, 1, 0, 1, -1);     // SW
    run(6'b000000, 6'b100000, 99, 0, 0, -1);    // imem timeout -> ERROR
    run(HALT, 6'b000000, 0, 0, 0, -1);          // HALT
    run(6'b100011, 6'b000000, 0, 0, 3, 4);      // reset mid-MEM
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1: begin op = 6'd0; fn = ($urandom_range(0, 1) != 0) ? 6'b011000 : 6'b011001; end
        2:    begin op = 6'd0; fn = 6'b001000; end
        3, 4: begin op = ($urandom_range(0, 1) != 0) ? 6'b100011 : 6'b101011; fn = 6'($urandom); end
        5:    begin op = ($urandom_range(0, 7) == 0) ? HALT : 6'($urandom); fn = 6'($urandom); end
        default: begin op = 6'($urandom); fn = 6'($urandom); end
      endcase
      run(op, fn, rnd_delay(), rnd_delay(), rnd_delay(), -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
